lms_err_monitor: RTL and testbench



---
 rtl/lms_mon_pkg.sv | 23 ++
 rtl/lms_err_square.sv | 121 ++++++++++++
 rtl/lms_err_monitor.sv | 177 +++++++++++++++++
 tb/tb_lms_err_monitor.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_mon_pkg.sv
// Shared types and constants for the LMS error monitor: FSM state encodings,
// default widths and the accumulator width helper.
package lms_mon_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE   = 2'd0,
        ST_CONVERGED = 2'd1,
        ST_DIVERGED  = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ERR_BITS     = 16;
    localparam int DEF_WIN_LOG2     = 6;
    localparam int DEF_HOLD_WINDOWS = 4;

    // Sum of 2^win_log2 squares of err_bits-wide values fits in this width.
    function automatic int acc_width(input int err_bits, input int win_log2);
        return 2 * err_bits + win_log2;
    endfunction

    localparam int DEF_ACC_W = acc_width(DEF_ERR_BITS, DEF_WIN_LOG2);

endpackage

// File: rtl/lms_err_square.sv
// Stages 1-2 of the LMS error monitor: saturate the filter error to ERR_BITS,
// then square it. Optional |error| output when LMS_MON_PEAK_EN is defined.
module lms_err_square
    import lms_mon_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ERR_BITS   = DEF_ERR_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] err_in,
    input  logic                  err_valid,
    output logic [2*ERR_BITS-1:0] sq,
    output logic                  sq_sat,
    output logic                  sq_valid
`ifdef LMS_MON_PEAK_EN
    ,
    output logic [ERR_BITS-1:0]   sq_abs
`endif
);

    localparam int SQ_W = 2 * ERR_BITS;

    localparam logic signed [DATA_WIDTH-1:0] IN_MAX_C =
        DATA_WIDTH'((64'sd1 <<< (ERR_BITS - 1)) - 64'sd1);
    localparam logic signed [DATA_WIDTH-1:0] IN_MIN_C =
        DATA_WIDTH'(-(64'sd1 <<< (ERR_BITS - 1)));
    localparam logic [ERR_BITS-1:0] SAT_MAX_C = {1'b0, {(ERR_BITS-1){1'b1}}};
    localparam logic [ERR_BITS-1:0] SAT_MIN_C = {1'b1, {(ERR_BITS-1){1'b0}}};

    logic [ERR_BITS-1:0] sat_val_s;
    logic                sat_flag_s;
    logic [ERR_BITS-1:0] s1_val_r;
    logic                s1_sat_r;
    logic                s1_valid_r;
    logic [SQ_W-1:0]     s1_ext_s;
    logic [SQ_W-1:0]     prod_s;
    logic [SQ_W-1:0]     sq_r;
    logic                sq_sat_r;
    logic                sq_valid_r;

    // Clamp the incoming error to the signed ERR_BITS range and flag clamping.
    always_comb begin
        sat_val_s  = err_in[ERR_BITS-1:0];
        sat_flag_s = 1'b0;
        if ($signed(err_in) > IN_MAX_C) begin
            sat_val_s  = SAT_MAX_C;
            sat_flag_s = 1'b1;
        end else if ($signed(err_in) < IN_MIN_C) begin
            sat_val_s  = SAT_MIN_C;
            sat_flag_s = 1'b1;
        end else begin
            sat_val_s  = err_in[ERR_BITS-1:0];
            sat_flag_s = 1'b0;
        end
    end

    // Stage 1 register: saturated sample, sat flag and valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_val_r   <= {ERR_BITS{1'b0}};
            s1_sat_r   <= 1'b0;
            s1_valid_r <= 1'b0;
        end else begin
            s1_val_r   <= sat_val_s;
            s1_sat_r   <= sat_flag_s;
            s1_valid_r <= err_valid;
        end
    end

    // Low SQ_W bits of the sign-extended product are the exact square,
    // since the result never exceeds 2^(SQ_W-2).
    assign s1_ext_s = {{ERR_BITS{s1_val_r[ERR_BITS-1]}}, s1_val_r};
    assign prod_s   = s1_ext_s * s1_ext_s;

    // Stage 2 register: square, sat flag and valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_r       <= {SQ_W{1'b0}};
            sq_sat_r   <= 1'b0;
            sq_valid_r <= 1'b0;
        end else begin
            sq_r       <= prod_s;
            sq_sat_r   <= s1_sat_r;
            sq_valid_r <= s1_valid_r;
        end
    end

`ifdef LMS_MON_PEAK_EN
    logic [ERR_BITS-1:0] abs_s;
    logic [ERR_BITS-1:0] abs_r;

    // Magnitude of the saturated sample; the most negative value maps to max.
    always_comb begin
        abs_s = s1_val_r;
        if (s1_val_r == SAT_MIN_C) begin
            abs_s = SAT_MAX_C;
        end else if (s1_val_r[ERR_BITS-1]) begin
            abs_s = (~s1_val_r) + {{(ERR_BITS-1){1'b0}}, 1'b1};
        end else begin
            abs_s = s1_val_r;
        end
    end

    // Stage 2 register for the magnitude.
    always_ff @(posedge clk) begin
        if (reset) begin
            abs_r <= {ERR_BITS{1'b0}};
        end else begin
            abs_r <= abs_s;
        end
    end

    assign sq_abs = abs_r;
`endif

    assign sq       = sq_r;
    assign sq_sat   = sq_sat_r;
    assign sq_valid = sq_valid_r;

endmodule

// File: rtl/lms_err_monitor.sv
// Windowed MSE monitor for the LMS filter error with an acquire/converged/
// diverged state machine. Define LMS_MON_PEAK_EN to add the err_peak output.
module lms_err_monitor
    import lms_mon_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ERR_BITS     = DEF_ERR_BITS,
    parameter int WIN_LOG2     = DEF_WIN_LOG2,
    parameter int HOLD_WINDOWS = DEF_HOLD_WINDOWS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] err_in,
    input  logic                  err_valid,
    input  logic [2*ERR_BITS-1:0] thresh_lo,
    input  logic [2*ERR_BITS-1:0] thresh_hi,
    output logic [2*ERR_BITS-1:0] mse_out,
    output logic                  mse_valid,
    output logic                  mse_sat,
    output logic [1:0]            state_out,
    output logic                  converged
`ifdef LMS_MON_PEAK_EN
    ,
    output logic [ERR_BITS-1:0]   err_peak
`endif
);

    localparam int SQ_W  = 2 * ERR_BITS;
    localparam int ACC_W = acc_width(ERR_BITS, WIN_LOG2);
    localparam logic [WIN_LOG2-1:0] CNT_LAST_C = {WIN_LOG2{1'b1}};
    localparam logic [3:0]          HOLD_C     = 4'(HOLD_WINDOWS);

    logic [SQ_W-1:0]     sq_s;
    logic                sq_sat_s;
    logic                sq_valid_s;
    logic [ACC_W-1:0]    acc_r;
    logic [ACC_W-1:0]    acc_sum_s;
    logic [WIN_LOG2-1:0] cnt_r;
    logic                sticky_r;
    logic                win_done_s;
    logic [SQ_W-1:0]     mse_new_s;
    logic                mse_lt_lo_s;
    logic                mse_gt_hi_s;
    logic [SQ_W-1:0]     mse_out_r;
    logic                mse_valid_r;
    logic                mse_sat_r;
    state_t              state_r;
    logic [3:0]          good_cnt_r;
    logic                converged_r;

`ifdef LMS_MON_PEAK_EN
    logic [ERR_BITS-1:0] sq_abs_s;
    logic [ERR_BITS-1:0] peak_run_r;
    logic [ERR_BITS-1:0] peak_max_s;
    logic [ERR_BITS-1:0] err_peak_r;
`endif

    lms_err_square #(
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_BITS   (ERR_BITS)
    ) u_square (
        .clk       (clk),
        .reset     (reset),
        .err_in    (err_in),
        .err_valid (err_valid),
        .sq        (sq_s),
        .sq_sat    (sq_sat_s),
        .sq_valid  (sq_valid_s)
`ifdef LMS_MON_PEAK_EN
        ,
        .sq_abs    (sq_abs_s)
`endif
    );

    assign acc_sum_s   = acc_r + {{WIN_LOG2{1'b0}}, sq_s};
    assign win_done_s  = sq_valid_s && (cnt_r == CNT_LAST_C);
    assign mse_new_s   = acc_sum_s[ACC_W-1:WIN_LOG2];
    assign mse_lt_lo_s = (mse_new_s < thresh_lo);
    assign mse_gt_hi_s = (mse_new_s > thresh_hi);

    // Stage 3: accumulate squares and publish the window mean on the last sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {WIN_LOG2{1'b0}};
            sticky_r    <= 1'b0;
            mse_out_r   <= {SQ_W{1'b0}};
            mse_sat_r   <= 1'b0;
            mse_valid_r <= 1'b0;
        end else begin
            mse_valid_r <= win_done_s;
            if (win_done_s) begin
                mse_out_r <= mse_new_s;
                mse_sat_r <= sticky_r | sq_sat_s;
                acc_r     <= {ACC_W{1'b0}};
                cnt_r     <= {WIN_LOG2{1'b0}};
                sticky_r  <= 1'b0;
            end else if (sq_valid_s) begin
                acc_r    <= acc_sum_s;
                cnt_r    <= cnt_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
                sticky_r <= sticky_r | sq_sat_s;
            end
        end
    end

    // Convergence FSM, stepped once per completed window with the fresh MSE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_ACQUIRE;
            good_cnt_r  <= 4'd0;
            converged_r <= 1'b0;
        end else if (win_done_s) begin
            case (state_r)
                ST_ACQUIRE: begin
                    if (mse_lt_lo_s) begin
                        // >= lets a recovery (which starts at 1) still converge for HOLD_WINDOWS=1
                        if ((good_cnt_r + 4'd1) >= HOLD_C) begin
                            state_r     <= ST_CONVERGED;
                            good_cnt_r  <= 4'd0;
                            converged_r <= 1'b1;
                        end else begin
                            good_cnt_r  <= good_cnt_r + 4'd1;
                        end
                    end else begin
                        good_cnt_r <= 4'd0;
                    end
                end
                ST_CONVERGED: begin
                    if (mse_gt_hi_s) begin
                        state_r     <= ST_DIVERGED;
                        converged_r <= 1'b0;
                    end else begin
                        converged_r <= 1'b1;
                    end
                end
                ST_DIVERGED: begin
                    if (mse_lt_lo_s) begin
                        state_r    <= ST_ACQUIRE;
                        good_cnt_r <= 4'd1;
                    end
                    converged_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_ACQUIRE;
                    good_cnt_r  <= 4'd0;
                    converged_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef LMS_MON_PEAK_EN
    assign peak_max_s = (sq_abs_s > peak_run_r) ? sq_abs_s : peak_run_r;

    // Running window peak of |error|, published alongside mse_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_run_r <= {ERR_BITS{1'b0}};
            err_peak_r <= {ERR_BITS{1'b0}};
        end else if (win_done_s) begin
            err_peak_r <= peak_max_s;
            peak_run_r <= {ERR_BITS{1'b0}};
        end else if (sq_valid_s) begin
            peak_run_r <= peak_max_s;
        end
    end

    assign err_peak = err_peak_r;
`endif

    assign mse_out   = mse_out_r;
    assign mse_valid = mse_valid_r;
    assign mse_sat   = mse_sat_r;
    assign state_out = state_r;
    assign converged = converged_r;

endmodule

// File: tb/tb_lms_err_monitor.sv
// Scoreboard bench for lms_err_monitor (WIN_LOG2=2, HOLD_WINDOWS=4); peak
// checks are compiled in when LMS_MON_PEAK_EN is defined.
module tb_lms_err_monitor;

    localparam int DW = 32;
    localparam int EB = 16;
    localparam int WL = 2;
    localparam int HW = 4;
    localparam int SMAX = (1 << (EB - 1)) - 1;
    localparam int SMIN = -(1 << (EB - 1));

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   err_in;
    logic            err_valid;
    logic [2*EB-1:0] thresh_lo;
    logic [2*EB-1:0] thresh_hi;
    logic [2*EB-1:0] mse_out;
    logic            mse_valid;
    logic            mse_sat;
    logic [1:0]      state_out;
    logic            converged;
`ifdef LMS_MON_PEAK_EN
    logic [EB-1:0]   err_peak;
`endif

    lms_err_monitor #(
        .DATA_WIDTH   (DW),
        .ERR_BITS     (EB),
        .WIN_LOG2     (WL),
        .HOLD_WINDOWS (HW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .err_in    (err_in),
        .err_valid (err_valid),
        .thresh_lo (thresh_lo),
        .thresh_hi (thresh_hi),
        .mse_out   (mse_out),
        .mse_valid (mse_valid),
        .mse_sat   (mse_sat),
        .state_out (state_out),
        .converged (converged)
`ifdef LMS_MON_PEAK_EN
        ,
        .err_peak  (err_peak)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint mse;
        logic   sat;
        logic [1:0] st;
        logic   conv;
        int     peak;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   mv_count = 0;
    int   exp_count = 0;
    int   last_cap_cyc = 0;
    int   last_mv_cyc = 0;
    int   m_state = 0;
    int   m_good = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat_e(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    // Monitor: pop the scoreboard on every mse_valid and compare all outputs.
    always @(negedge clk) begin
        if (mse_valid === 1'b1) begin
            exp_t e;
            mv_count    = mv_count + 1;
            last_mv_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_tests = n_tests + 1;
                n_fail  = n_fail + 1;
                $display("FAIL unexpected_mse_valid: got mse_out=%0d with nothing expected", mse_out);
            end else begin
                e = exp_q.pop_front();
                n_tests = n_tests + 4;
                if (mse_out !== e.mse[2*EB-1:0]) begin
                    n_fail = n_fail + 1;
                    $display("FAIL mse_out: got %0d expected %0d", mse_out, e.mse);
                end
                if (mse_sat !== e.sat) begin
                    n_fail = n_fail + 1;
                    $display("FAIL mse_sat: got %0b expected %0b", mse_sat, e.sat);
                end
                if (state_out !== e.st) begin
                    n_fail = n_fail + 1;
                    $display("FAIL state_out: got %0d expected %0d", state_out, e.st);
                end
                if (converged !== e.conv) begin
                    n_fail = n_fail + 1;
                    $display("FAIL converged: got %0b expected %0b", converged, e.conv);
                end
`ifdef LMS_MON_PEAK_EN
                n_tests = n_tests + 1;
                if (err_peak !== e.peak[EB-1:0]) begin
                    n_fail = n_fail + 1;
                    $display("FAIL err_peak: got %0d expected %0d", err_peak, e.peak);
                end
`endif
            end
        end
    end

    task automatic drive(input int v);
        err_in    = v;
        err_valid = 1'b1;
        @(posedge clk);
        #1;
        last_cap_cyc = cyc;
        err_valid    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset   = 1'b0;
        m_state = 0;
        m_good  = 0;
    endtask

    // Compute the expected window result, push it, then drive the samples.
    task automatic run_window(input int s0, input int s1, input int s2, input int s3, input int gap);
        int     s[4];
        longint sum;
        exp_t   e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        sum = 0;
        e.sat  = 1'b0;
        e.peak = 0;
        for (int i = 0; i < 4; i++) begin
            int x;
            int a;
            x = sat_e(s[i]);
            if (x != s[i]) e.sat = 1'b1;
            a = (x == SMIN) ? SMAX : ((x < 0) ? -x : x);
            if (a > e.peak) e.peak = a;
            sum = sum + longint'(x) * longint'(x);
        end
        e.mse = sum >> WL;
        case (m_state)
            0: begin
                if (e.mse < longint'(thresh_lo)) begin
                    m_good = m_good + 1;
                    if (m_good >= HW) begin
                        m_state = 1;
                        m_good  = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end
            1: if (e.mse > longint'(thresh_hi)) m_state = 2;
            default: begin
                if (e.mse < longint'(thresh_lo)) begin
                    m_state = 0;
                    m_good  = 1;
                end
            end
        endcase
        e.st   = m_state[1:0];
        e.conv = (m_state == 1);
        exp_q.push_back(e);
        exp_count = exp_count + 1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) idle(gap);
            drive(s[i]);
        end
    endtask

    task automatic wait_mv(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mv_count >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        err_valid = 1'b0;
        err_in    = '0;
        thresh_lo = 32'd10;
        thresh_hi = 32'd100;
        idle(3);
        n_tests = n_tests + 5;
        if (mse_out !== 32'd0) begin n_fail++; $display("FAIL reset_mse_out: got %0d expected 0", mse_out); end
        if (mse_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mse_valid: got %0b expected 0", mse_valid); end
        if (mse_sat !== 1'b0) begin n_fail++; $display("FAIL reset_mse_sat: got %0b expected 0", mse_sat); end
        if (state_out !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_out); end
        if (converged !== 1'b0) begin n_fail++; $display("FAIL reset_converged: got %0b expected 0", converged); end
        reset   = 1'b0;
        m_state = 0;
        m_good  = 0;
        idle(2);
    endtask

    task automatic test_window_latency();
        bit ok;
        run_window(3, 3, 3, 3, 0);
        wait_mv(exp_count, ok);
        n_tests = n_tests + 3;
        if (!ok) begin
            n_fail++;
            $display("FAIL latency_timeout: got %0d pulses expected %0d", mv_count, exp_count);
        end
        if ((last_mv_cyc - (last_cap_cyc - 1)) != 3) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles expected 3", last_mv_cyc - (last_cap_cyc - 1));
        end
        if (mse_out !== 32'd9) begin
            n_fail++;
            $display("FAIL window_value: got %0d expected 9", mse_out);
        end
        @(negedge clk);
        n_tests = n_tests + 1;
        if (mse_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width: got mse_valid=%0b expected 0", mse_valid);
        end
        idle(2);
    endtask

    task automatic test_gaps_sat();
        bit ok;
        run_window(32'h0001_0000, -5, 5, -5, 3);
        wait_mv(exp_count, ok);
        idle(6);
        n_tests = n_tests + 3;
        if (!ok) begin n_fail++; $display("FAIL gaps_timeout: got %0d pulses expected %0d", mv_count, exp_count); end
        if (mse_out !== 32'd268419091) begin n_fail++; $display("FAIL gaps_value: got %0d expected 268419091", mse_out); end
        if (mv_count != exp_count) begin n_fail++; $display("FAIL gaps_pulses: got %0d expected %0d", mv_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        drive(7);
        drive(7);
        idle(2);
        do_reset();
        run_window(2, 2, 2, 2, 0);
        wait_mv(exp_count, ok);
        idle(6);
        n_tests = n_tests + 4;
        if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got %0d pulses expected %0d", mv_count, exp_count); end
        if (mse_out !== 32'd4) begin n_fail++; $display("FAIL rstmid_value: got %0d expected 4", mse_out); end
        if (state_out !== 2'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d expected 0", state_out); end
        if (mv_count != exp_count) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected %0d", mv_count, exp_count); end
    endtask

    task automatic test_convergence();
        bit ok;
        do_reset();
        for (int w = 0; w < 7; w++) begin
            if (w == 2) run_window(6, 2, 0, 0, 0);
            else        run_window(2, 2, 2, 2, 0);
            wait_mv(exp_count, ok);
            n_tests = n_tests + 1;
            if (!ok) begin n_fail++; $display("FAIL conv_timeout: window %0d got %0d pulses", w, mv_count); end
            if (w == 5) begin
                n_tests = n_tests + 1;
                if (state_out !== 2'd0) begin n_fail++; $display("FAIL conv_early: got %0d expected 0", state_out); end
            end
        end
        n_tests = n_tests + 2;
        if (state_out !== 2'd1) begin n_fail++; $display("FAIL conv_state: got %0d expected 1", state_out); end
        if (converged !== 1'b1) begin n_fail++; $display("FAIL conv_flag: got %0b expected 1", converged); end
    endtask

    task automatic test_divergence();
        bit ok;
        int s0[7];
        int s1[7];
        s0 = '{20, 20, 14, 6, 6, 6, 6};
        s1 = '{0, 2, 2, 0, 0, 0, 0};
        for (int w = 0; w < 7; w++) begin
            run_window(s0[w], s1[w], 0, 0, 1);
            wait_mv(exp_count, ok);
            n_tests = n_tests + 1;
            if (!ok) begin n_fail++; $display("FAIL div_timeout: window %0d got %0d pulses", w, mv_count); end
            if (w == 1) begin
                n_tests = n_tests + 1;
                if (state_out !== 2'd2) begin n_fail++; $display("FAIL div_state: got %0d expected 2", state_out); end
            end
        end
        n_tests = n_tests + 1;
        if (state_out !== 2'd1) begin n_fail++; $display("FAIL recover_state: got %0d expected 1", state_out); end
    endtask

`ifdef LMS_MON_PEAK_EN
    task automatic test_peak();
        bit ok;
        run_window(-7, 3, -32768, 1, 0);
        wait_mv(exp_count, ok);
        n_tests = n_tests + 1;
        if (err_peak !== 16'd32767) begin n_fail++; $display("FAIL peak_min: got %0d expected 32767", err_peak); end
        run_window(1, -2, 1, 0, 0);
        wait_mv(exp_count, ok);
        n_tests = n_tests + 2;
        if (!ok) begin n_fail++; $display("FAIL peak_timeout: got %0d pulses expected %0d", mv_count, exp_count); end
        if (err_peak !== 16'd2) begin n_fail++; $display("FAIL peak_small: got %0d expected 2", err_peak); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_window_latency();
        test_gaps_sat();
        test_reset_mid();
        test_convergence();
        test_divergence();
`ifdef LMS_MON_PEAK_EN
        test_peak();
`endif
        idle(4);
        n_tests = n_tests + 1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
